// File: rtl/count_timer_arbiter_pkg.sv
// count_timer_arbiter_pkg: shared state encoding and default widths for the counter arbiter
package count_timer_arbiter_pkg;
  localparam int DUR_W_DEF = 10;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_t;
endpackage

// File: rtl/count_timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set bit at or above ptr, wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    // Walk downward so the candidate closest to ptr is assigned last and wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        pick = '0;
        pick[IW'((int'(ptr) + k) % N)] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/count_timer_arbiter.sv
// count_timer_arbiter: round-robin sharing of one seconds counter between NUM_REQ timer users
module count_timer_arbiter
  import count_timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DUR_W   = DUR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] req_dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     beginCount,
  output logic [DUR_W-1:0]         counterSeconds,
  input  logic                     tmr_done,
  output logic                     tmr_abort
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, owner, pidx;
  logic [NUM_REQ-1:0] pick;
  logic any, wd;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pidx),
    .any  (any)
  );
  assign busy       = state != IDLE;
  assign beginCount = state == START;
  assign done       = state == FINISH ? grant : '0;
  // Completion in RUN takes priority over a same-cycle withdrawal
  always_comb begin
    wd  = (state == LOAD || state == START || state == RUN) && !req[owner] && !(state == RUN && tmr_done);
    nxt = state == IDLE  ? (any ? LOAD : IDLE) :
          wd             ? IDLE :
          state == LOAD  ? (counterSeconds == '0 ? FINISH : START) :
          state == START ? RUN :
          state == RUN   ? (tmr_done ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      grant          <= '0;
      counterSeconds <= '0;
      tmr_abort      <= 1'b0;
    end else begin
      state     <= nxt;
      tmr_abort <= wd;
      if (state == IDLE && any) begin
        grant          <= pick;
        owner          <= pidx;
        counterSeconds <= req_dur[pidx*DUR_W +: DUR_W];
      end
      if (state == FINISH || wd) begin
        grant          <= '0;
        counterSeconds <= '0;
        rr_ptr         <= owner == IW'(NUM_REQ - 1) ? '0 : owner + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_count_timer_arbiter.sv
// tb_count_timer_arbiter: table-driven and scoreboard checks of the counter arbiter with a counter model
module tb_count_timer_arbiter;
  localparam int N = 4, W = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_dur = '0;
  logic [N-1:0] grant, done;
  logic busy, beginCount, tmr_done, tmr_abort;
  logic [W-1:0] counterSeconds;
  logic tmr_force = 1'b0;
  logic [W-1:0] cnt;
  logic active;
  int checks = 0, errors = 0, begin_cnt = 0, abort_cnt = 0;
  logic [N-1:0] exp_q[$];
  typedef struct {
    logic [N-1:0] rq;
    logic [W-1:0] dur;
    logic [N-1:0] eg;
    int           nbeg;
  } vec_t;
  vec_t tbl[6];
  logic [N-1:0] order[5];
  always #5 clk = ~clk;
  count_timer_arbiter #(.NUM_REQ(N), .DUR_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_dur        (req_dur),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .beginCount     (beginCount),
    .counterSeconds (counterSeconds),
    .tmr_done       (tmr_done),
    .tmr_abort      (tmr_abort)
  );
  // Counter model: tmr_done rises counterSeconds cycles after beginCount
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (tmr_abort) active <= 1'b0;
    else if (beginCount) begin
      active <= counterSeconds != '0;
      cnt    <= counterSeconds - 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else cnt <= cnt - 1'b1;
    end
  end
  assign tmr_done = tmr_force || (active && cnt == '0);
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (beginCount) begin_cnt++;
      if (tmr_abort) abort_cnt++;
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got %0h expected none", done);
        end else chk("sb_done", done, exp_q.pop_front());
      end
      chk("grant_onehot", $countones(grant) <= 1, 1);
      chk("begin_abort_excl", beginCount && tmr_abort, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, b0, a0;
    tbl[0] = '{4'b0001, 10'd5, 4'b0001, 1};
    tbl[1] = '{4'b0110, 10'd3, 4'b0010, 1};
    tbl[2] = '{4'b0011, 10'd1, 4'b0001, 1};
    tbl[3] = '{4'b1100, 10'd0, 4'b0100, 0};
    tbl[4] = '{4'b0101, 10'd2, 4'b0001, 1};
    tbl[5] = '{4'b1001, 10'd4, 4'b1000, 1};
    order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_begin", beginCount, 0);
    chk("rst_cs", counterSeconds, 0);
    chk("rst_abort", tmr_abort, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      req_dur = {N{tbl[i].dur}};
      b0 = begin_cnt;
      exp_q.push_back(tbl[i].eg);
      req = tbl[i].rq;
      tick();
      chk($sformatf("v%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("v%0d_busy", i), busy, 1);
      n = 0;
      while (done == '0 && n < 300) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d_latency", i), n, tbl[i].dur == 0 ? 1 : tbl[i].dur + 2);
      chk($sformatf("v%0d_cs", i), counterSeconds, tbl[i].dur);
      chk($sformatf("v%0d_begins", i), begin_cnt - b0, tbl[i].nbeg);
      req = '0;
      tick();
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      chk($sformatf("v%0d_grant_after", i), grant, 0);
    end
    req_dur = {N{10'd2}};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(order[k]);
      n = 0;
      while (grant == '0 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("rr%0d_grant", k), grant, order[k]);
      b0 = begin_cnt;
      n = 0;
      while (done == '0 && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("rr%0d_done_seen", k), n < 50, 1);
      chk($sformatf("rr%0d_begins", k), begin_cnt - b0, 1);
      if (k == 4) req = '0;
      tick();
      chk($sformatf("rr%0d_idle_grant", k), grant, 0);
    end
    req_dur = {10'd7, 10'd0, 10'd7, 10'd7};
    tmr_force = 1'b1;
    b0 = begin_cnt;
    exp_q.push_back(4'b0100);
    req = 4'b0100;
    tick();
    chk("zd_grant", grant, 4'b0100);
    tick();
    chk("zd_done", done, 4'b0100);
    chk("zd_no_begin", begin_cnt - b0, 0);
    tmr_force = 1'b0;
    req = '0;
    tick();
    chk("zd_busy_after", busy, 0);
    req_dur = {10'd0, 10'd0, 10'd100, 10'd3};
    a0 = abort_cnt;
    exp_q.push_back(4'b0001);
    req = 4'b0010;
    tick();
    chk("wd_grant", grant, 4'b0010);
    req = 4'b0011;
    n = 0;
    while (!beginCount && n < 10) begin
      tick();
      n++;
    end
    chk("wd_begin_seen", beginCount, 1);
    repeat (11) tick();
    chk("wd_still_run", grant, 4'b0010);
    req = 4'b0001;
    tick();
    chk("wd_abort", tmr_abort, 1);
    chk("wd_grant_clr", grant, 0);
    chk("wd_no_done", done, 0);
    tick();
    chk("wd_abort_pulse", tmr_abort, 0);
    chk("wd_next_grant", grant, 4'b0001);
    n = 0;
    while (done == '0 && n < 50) begin
      tick();
      n++;
    end
    chk("wd_next_done_seen", n < 50, 1);
    req = '0;
    tick();
    chk("wd_abort_count", abort_cnt - a0, 1);
    req_dur = {10'd0, 10'd0, 10'd100, 10'd0};
    a0 = abort_cnt;
    exp_q.push_back(4'b0010);
    req = 4'b0010;
    tick();
    chk("co_grant", grant, 4'b0010);
    n = 0;
    while (!beginCount && n < 10) begin
      tick();
      n++;
    end
    repeat (3) tick();
    req = '0;
    tmr_force = 1'b1;
    tick();
    chk("co_done", done, 4'b0010);
    chk("co_abort", tmr_abort, 0);
    tmr_force = 1'b0;
    tick();
    chk("co_abort_after", tmr_abort, 0);
    chk("co_busy_after", busy, 0);
    chk("co_abort_count", abort_cnt - a0, 0);
    req_dur = {10'd0, 10'd0, 10'd2, 10'd50};
    req = 4'b0001;
    tick();
    chk("ar_grant", grant, 4'b0001);
    n = 0;
    while (!beginCount && n < 10) begin
      tick();
      n++;
    end
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    chk("ar_grant_rst", grant, 0);
    chk("ar_busy_rst", busy, 0);
    chk("ar_cs_rst", counterSeconds, 0);
    chk("ar_begin_rst", beginCount, 0);
    req = '0;
    tick();
    reset = 1'b0;
    exp_q.push_back(4'b0010);
    req = 4'b1010;
    tick();
    chk("ar_ptr_grant", grant, 4'b0010);
    n = 0;
    while (done == '0 && n < 50) begin
      tick();
      n++;
    end
    chk("ar_done_seen", n < 50, 1);
    req = '0;
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
